// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, occupancy states and
// MIPS instruction field positions.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/decode_field_decoder.sv
// Combinational MIPS field splitter with sign-extended immediate and
// word-aligned branch offset.
module field_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_ext,
    output logic [31:0] branch_offset
);

    assign opcode        = instr[OPCODE_LSB +: 6];
    assign rs            = instr[RS_LSB +: 5];
    assign rt            = instr[RT_LSB +: 5];
    assign rd            = instr[RD_LSB +: 5];
    assign shamt         = instr[SHAMT_LSB +: 5];
    assign funct         = instr[FUNCT_LSB +: 6];
    assign imm_ext       = sign_ext16(instr[IMM_MSB:0]);
    assign branch_offset = {imm_ext[29:0], 2'b00};

endmodule

// File: rtl/decode_stage.sv
// Decode stage: two-entry skid buffer feeding a field decoder on the head word.
// Optional DECODE_PERF_EN adds pop and stall counters.
//   state | meaning
//   EMPTY | no valid entry
//   ONE   | main holds the head word
//   TWO   | main and skid both valid, upstream stalled
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc4,
    output logic        in_ready,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_ext,
    output logic [31:0] branch_offset,
`ifdef DECODE_PERF_EN
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall,
`endif
    output logic        is_branch
);

    state_t      state, state_n;
    logic [31:0] main_instr, main_instr_n, main_pc4, main_pc4_n;
    logic [31:0] skid_instr, skid_instr_n, skid_pc4, skid_pc4_n;
    logic        main_valid, main_valid_n, skid_valid, skid_valid_n;
    logic        push, pop;

    assign in_ready  = (state != TWO) && !reset;
    assign out_valid = main_valid && !reset;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            main_instr <= '0;
            main_pc4   <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            main_instr <= main_instr_n;
            main_pc4   <= main_pc4_n;
            skid_instr <= skid_instr_n;
            skid_pc4   <= skid_pc4_n;
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        main_instr_n = main_instr;
        main_pc4_n   = main_pc4;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;
        // Flush discards any same-cycle push but leaves data registers alone.
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_n      = ONE;
                        main_instr_n = in_instr;
                        main_pc4_n   = in_pc4;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_instr_n = in_instr;
                        main_pc4_n   = in_pc4;
                    end else if (push) begin
                        state_n      = TWO;
                        skid_instr_n = in_instr;
                        skid_pc4_n   = in_pc4;
                    end else if (pop) begin
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_n      = ONE;
                        main_instr_n = skid_instr;
                        main_pc4_n   = skid_pc4;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
        main_valid_n = (state_n != EMPTY);
        skid_valid_n = (state_n == TWO);
    end

    assign out_instr = main_instr;
    assign out_pc4   = main_pc4;

    field_decoder u_field_decoder (
        .instr         (main_instr),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .funct         (funct),
        .imm_ext       (imm_ext),
        .branch_offset (branch_offset)
    );

    assign is_branch = out_valid && (opcode == OP_BEQ);

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (pop)
                perf_issued <= perf_issued + 32'd1;
            if (in_valid && !in_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus queues expected vector indices,
// a negedge monitor compares every popped head word against the table.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc4;
    logic        in_ready, out_valid, is_branch;
    logic [31:0] out_instr, out_pc4, imm_ext, branch_offset;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
    int          m_issued, m_stall;
`endif

    decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_pc4        (in_pc4),
        .in_ready      (in_ready),
        .flush         (flush),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc4       (out_pc4),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .funct         (funct),
        .imm_ext       (imm_ext),
        .branch_offset (branch_offset),
`ifdef DECODE_PERF_EN
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall),
`endif
        .is_branch     (is_branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [31:0] off;
        logic        br;
    } vec_t;

    vec_t vecs[7];
    int   exp_q[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head word must match the oldest queued vector.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !flush) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", out_instr, 32'h0);
                failures += (out_instr === 32'h0) ? 1 : 0;
            end else begin
                int i;
                i = exp_q.pop_front();
                chk("out_instr", out_instr, vecs[i].instr);
                chk("out_pc4", out_pc4, vecs[i].pc4);
                chk("opcode", {26'd0, opcode}, {26'd0, vecs[i].opcode});
                chk("rs", {27'd0, rs}, {27'd0, vecs[i].rs});
                chk("rt", {27'd0, rt}, {27'd0, vecs[i].rt});
                chk("rd", {27'd0, rd}, {27'd0, vecs[i].rd});
                chk("shamt", {27'd0, shamt}, {27'd0, vecs[i].shamt});
                chk("funct", {26'd0, funct}, {26'd0, vecs[i].funct});
                chk("imm_ext", imm_ext, vecs[i].imm);
                chk("branch_offset", branch_offset, vecs[i].off);
                chk("is_branch", {31'd0, is_branch}, {31'd0, vecs[i].br});
            end
        end
    end

`ifdef DECODE_PERF_EN
    always @(negedge clk) begin
        if (reset) begin
            m_issued = 0;
            m_stall  = 0;
        end else begin
            if (out_valid && out_ready) m_issued++;
            if (in_valid && !in_ready) m_stall++;
        end
    end
`endif

    task automatic push_vec(input int idx);
        bit done = 0;
        in_valid = 1'b1;
        in_instr = vecs[idx].instr;
        in_pc4   = vecs[idx].pc4;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(idx);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h1000FFFF, 32'h00000008, 6'h04, 5'd0,  5'd0,  5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b1};
        vecs[1] = '{32'h012A4020, 32'h0000000C, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 32'h00004020, 32'h00010080, 1'b0};
        vecs[2] = '{32'h8D280004, 32'h00000010, 6'h23, 5'd9,  5'd8,  5'd0,  5'd0,  6'h04, 32'h00000004, 32'h00000010, 1'b0};
        vecs[3] = '{32'hAFBFFFF8, 32'h00000014, 6'h2B, 5'd29, 5'd31, 5'd31, 5'd31, 6'h38, 32'hFFFFFFF8, 32'hFFFFFFE0, 1'b0};
        vecs[4] = '{32'h11090003, 32'h00000018, 6'h04, 5'd8,  5'd9,  5'd0,  5'd0,  6'h03, 32'h00000003, 32'h0000000C, 1'b1};
        vecs[5] = '{32'h10008000, 32'h0000001C, 6'h04, 5'd0,  5'd0,  5'd16, 5'd0,  6'h00, 32'hFFFF8000, 32'hFFFE0000, 1'b1};
        vecs[6] = '{32'h10007FFF, 32'h00000020, 6'h04, 5'd0,  5'd0,  5'd15, 5'd31, 6'h3F, 32'h00007FFF, 32'h0001FFFC, 1'b1};

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc4 = 32'h0;

        // Reset: everything reads zero, in_ready held low.
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        idle(2);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_is_branch", {31'd0, is_branch}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc4", out_pc4, 32'd0);
        chk("rst_imm_ext", imm_ext, 32'd0);
        chk("rst_branch_offset", branch_offset, 32'd0);
`ifdef DECODE_PERF_EN
        chk("rst_perf_issued", perf_issued, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Single beq: visible one cycle after the push.
        out_ready = 1'b1;
        push_vec(0);
        @(negedge clk);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        idle(1);

        // Back-to-back stream at full throughput.
        for (int i = 1; i < 7; i++) push_vec(i);
        idle(3);
        chk("stream_drained", exp_q.size(), 32'd0);

        // Backpressure: A and B fill the buffer, C waits upstream.
        out_ready = 1'b0;
        push_vec(1);
        push_vec(2);
        @(negedge clk);
        chk("two_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = vecs[3].instr; in_pc4 = vecs[3].pc4;
        idle(2);
        @(negedge clk);
        chk("held_in_ready", {31'd0, in_ready}, 32'd0);
        chk("held_head", out_instr, vecs[1].instr);
        @(posedge clk); #1;
        pop_cyc.delete();
        out_ready = 1'b1;
        push_vec(3);
        idle(3);
        chk("abc_pop_count", pop_cyc.size(), 32'd3);
        if (pop_cyc.size() >= 3)
            chk("abc_consecutive", pop_cyc[2] - pop_cyc[0], 32'd2);
        chk("abc_drained", exp_q.size(), 32'd0);

        // Flush in TWO together with an upstream word.
        out_ready = 1'b0;
        push_vec(4);
        push_vec(5);
        in_valid = 1'b1; in_instr = vecs[6].instr; in_pc4 = vecs[6].pc4;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_two_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_two_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Flush in ONE where the same-cycle push would otherwise be taken.
        push_vec(4);
        in_valid = 1'b1; in_instr = vecs[5].instr; in_pc4 = vecs[5].pc4;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_one_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(4);

        // Data still flows after flush.
        push_vec(0);
        idle(2);
        chk("post_flush_drained", exp_q.size(), 32'd0);

`ifdef DECODE_PERF_EN
        @(negedge clk);
        chk("perf_issued", perf_issued, m_issued);
        chk("perf_stall", perf_stall, m_stall);
        @(posedge clk); #1;
`endif

        // Reset mid-operation drops the buffered word and zeroes data.
        out_ready = 1'b0;
        push_vec(6);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_out_instr", out_instr, 32'd0);
        chk("midrst_imm_ext", imm_ext, 32'd0);
`ifdef DECODE_PERF_EN
        chk("midrst_perf_issued", perf_issued, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_release_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
